// File: rtl/corr_pkg.sv
// ============================================================================
//  Module      : corr_pkg
//  Description : Shared FSM state encoding and width helpers for the
//                sliding correlator.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package corr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to hold a match count of 0..w.
    function automatic int score_width(input int w);
        return $clog2(w + 1);
    endfunction

    function automatic int lag_width(input int max_lag);
        return (max_lag < 1) ? 1 : $clog2(max_lag + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sliding_correlator_if.sv
// ============================================================================
//  Module      : sliding_correlator_if
//  Description : Request/result bus between the correlator and its
//                controller (master) and the decision logic.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sliding_correlator_if #(
    parameter int W       = 16,
    parameter int MAX_LAG = 7
);
    import corr_pkg::*;

    localparam int SW = score_width(W);
    localparam int LW = lag_width(MAX_LAG);

    logic                   Start;
    logic [W-1:0]           DataIn1;
    logic [W+MAX_LAG-1:0]   DataIn2;
    logic                   Busy;
    logic                   OutValid;
    logic                   OutReady;
    logic [LW-1:0]          BestLag;
    logic [SW-1:0]          BestScore;
    logic                   Detect;
    logic                   Inverted;

    modport master (
        output Start, DataIn1, DataIn2, OutReady,
        input  Busy, OutValid, BestLag, BestScore, Detect, Inverted
    );

    modport slave (
        input  Start, DataIn1, DataIn2, OutReady,
        output Busy, OutValid, BestLag, BestScore, Detect, Inverted
    );

endinterface

`default_nettype wire

// File: rtl/xnor_popcount.sv
// ============================================================================
//  Module      : xnor_popcount
//  Description : Combinational count of equal bit positions in two W-bit words.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module xnor_popcount
    import corr_pkg::*;
#(
    parameter int W = 16
) (
    input  wire logic [W-1:0]                i_a,
    input  wire logic [W-1:0]                i_b,
    output      logic [score_width(W)-1:0]   o_count
);

    localparam int CW = score_width(W);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < W; i++) begin
            o_count = o_count + CW'(i_a[i] ~^ i_b[i]);
        end
    end

endmodule

`default_nettype wire

// File: rtl/sliding_correlator.sv
// ============================================================================
//  Module      : sliding_correlator
//  Description : Sweeps lags 0..MAX_LAG of an observation word against a
//                reference, one lag per cycle, and reports the best match.
//                Define CORR_ABS_EN to also score anti-correlation.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sliding_correlator
    import corr_pkg::*;
#(
    parameter int SAMPLES = 2,
    parameter int OSF     = 8,
    parameter int MAX_LAG = 7,
    parameter int THRESH  = 14
) (
    input  wire logic             Clk,
    input  wire logic             Rst_n,
    sliding_correlator_if.slave   bus
);

    localparam int W  = SAMPLES * OSF;
    localparam int OW = W + MAX_LAG;
    localparam int SW = score_width(W);
    localparam int LW = lag_width(MAX_LAG);

    localparam logic [LW-1:0] LAST_LAG = LW'(MAX_LAG);
    localparam logic [SW-1:0] THRESH_V = SW'(THRESH);

    state_t          state_q, state_d;
    logic [W-1:0]    ref_q, ref_d;
    logic [OW-1:0]   obs_q, obs_d;
    logic [LW-1:0]   lag_q, lag_d;
    logic [LW-1:0]   best_lag_q, best_lag_d;
    logic [SW-1:0]   best_score_q, best_score_d;
    logic            detect_q, detect_d;
    logic            inverted_q, inverted_d;
    logic            busy_q, busy_d;
    logic            valid_q, valid_d;

    logic [W-1:0]    window;
    logic [SW-1:0]   match;
    logic [SW-1:0]   score;
    logic            anti;

    assign window = obs_q[lag_q +: W];

    xnor_popcount #(.W(W)) u_popcount (
        .i_a     (ref_q),
        .i_b     (window),
        .o_count (match)
    );

`ifdef CORR_ABS_EN
    logic [SW-1:0] mismatch;
    assign mismatch = SW'(W) - match;
    // An exact half-split stays non-inverted.
    assign anti     = (mismatch > match);
    assign score    = anti ? mismatch : match;
`else
    assign anti  = 1'b0;
    assign score = match;
`endif

    always_comb begin
        state_d      = state_q;
        ref_d        = ref_q;
        obs_d        = obs_q;
        lag_d        = lag_q;
        best_lag_d   = best_lag_q;
        best_score_d = best_score_q;
        detect_d     = detect_q;
        inverted_d   = inverted_q;

        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    state_d      = SCAN;
                    ref_d        = bus.DataIn1;
                    obs_d        = bus.DataIn2;
                    lag_d        = '0;
                    best_lag_d   = '0;
                    best_score_d = '0;
                    detect_d     = 1'b0;
                    inverted_d   = 1'b0;
                end
            end
            SCAN: begin
                // Strict compare: on ties the earlier (smaller) lag wins.
                if ((lag_q == '0) || (score > best_score_q)) begin
                    best_lag_d   = lag_q;
                    best_score_d = score;
                    detect_d     = (score >= THRESH_V);
                    inverted_d   = anti;
                end
                if (lag_q == LAST_LAG) begin
                    state_d = DONE;
                end else begin
                    lag_d = lag_q + LW'(1);
                end
            end
            DONE: begin
                if (bus.OutReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d  = (state_d != IDLE);
        valid_d = (state_d == DONE);
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q      <= IDLE;
            ref_q        <= '0;
            obs_q        <= '0;
            lag_q        <= '0;
            best_lag_q   <= '0;
            best_score_q <= '0;
            detect_q     <= 1'b0;
            inverted_q   <= 1'b0;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ref_q        <= ref_d;
            obs_q        <= obs_d;
            lag_q        <= lag_d;
            best_lag_q   <= best_lag_d;
            best_score_q <= best_score_d;
            detect_q     <= detect_d;
            inverted_q   <= inverted_d;
            busy_q       <= busy_d;
            valid_q      <= valid_d;
        end
    end

    assign bus.Busy      = busy_q;
    assign bus.OutValid  = valid_q;
    assign bus.BestLag   = best_lag_q;
    assign bus.BestScore = best_score_q;
    assign bus.Detect    = detect_q;
    assign bus.Inverted  = inverted_q;

endmodule

`default_nettype wire

// File: tb/tb_sliding_correlator.sv
// ============================================================================
//  Module      : tb_sliding_correlator
//  Description : Scoreboard bench for sliding_correlator with a lag-sweep
//                reference model and randomized plus directed scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sliding_correlator;

    localparam int SAMPLES = 2;
    localparam int OSF     = 8;
    localparam int W       = SAMPLES * OSF;
    localparam int MAX_LAG = 7;
    localparam int THRESH  = 14;
    localparam int OW      = W + MAX_LAG;

    typedef struct packed {
        logic [2:0] lag;
        logic [4:0] score;
        logic       detect;
        logic       inv;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    sliding_correlator_if #(.W(W), .MAX_LAG(MAX_LAG)) bus ();

    sliding_correlator #(
        .SAMPLES (SAMPLES),
        .OSF     (OSF),
        .MAX_LAG (MAX_LAG),
        .THRESH  (THRESH)
    ) dut (
        .Clk   (clk),
        .Rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Try every alignment of the reference inside the observation; keep the first best.
    function automatic exp_t model(input logic [W-1:0] r, input logic [OW-1:0] o);
        exp_t e;
        int   best;
        best = -1;
        e    = '0;
        for (int l = 0; l <= MAX_LAG; l++) begin
            logic [OW-1:0] sh;
            logic [W-1:0]  win;
            int            m;
            int            s;
            bit            inv;
            sh  = o >> l;
            win = sh[W-1:0];
            m   = $countones(~(r ^ win));
            s   = m;
            inv = 1'b0;
`ifdef CORR_ABS_EN
            if (W - m > m) begin
                s   = W - m;
                inv = 1'b1;
            end
`endif
            if (s > best) begin
                best     = s;
                e.lag    = 3'(l);
                e.score  = 5'(s);
                e.inv    = inv;
            end
        end
        e.detect = (best >= THRESH);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare the result presented at each output handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.OutValid && bus.OutReady) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("best_lag",   32'(bus.BestLag),   32'(e.lag));
                    chk("best_score", 32'(bus.BestScore), 32'(e.score));
                    chk("detect",     32'(bus.Detect),    32'(e.detect));
                    chk("inverted",   32'(bus.Inverted),  32'(e.inv));
                end
            end
        end
    end

    task automatic run(input logic [W-1:0] r, input logic [OW-1:0] o, input int hold);
        exp_t e;
        int   lat;
        e = model(r, o);
        bus.Start    = 1'b1;
        bus.DataIn1  = r;
        bus.DataIn2  = o;
        bus.OutReady = 1'b0;
        tick();
        sb.push_back(e);
        chk("busy_after_accept", 32'(bus.Busy), 32'd1);
        chk("valid_after_accept", 32'(bus.OutValid), 32'd0);
        lat = 0;
        while (!bus.OutValid && lat < 40) begin
            bus.Start   = 1'($urandom_range(0, 1));
            bus.DataIn1 = W'($urandom);
            bus.DataIn2 = OW'($urandom);
            tick();
            lat++;
        end
        chk("latency", 32'(lat), 32'(MAX_LAG + 1));
        for (int i = 0; i < hold; i++) begin
            bus.Start   = 1'b1;
            bus.DataIn1 = W'($urandom);
            tick();
            chk("hold_valid", 32'(bus.OutValid),  32'd1);
            chk("hold_busy",  32'(bus.Busy),      32'd1);
            chk("hold_lag",   32'(bus.BestLag),   32'(e.lag));
            chk("hold_score", 32'(bus.BestScore), 32'(e.score));
        end
        // Start raised together with the handshake must be ignored.
        bus.Start    = 1'b1;
        bus.OutReady = 1'b1;
        tick();
        chk("valid_drop", 32'(bus.OutValid), 32'd0);
        chk("busy_drop",  32'(bus.Busy),     32'd0);
        bus.Start    = 1'b0;
        bus.OutReady = 1'b0;
        tick();
        chk("idle_busy",  32'(bus.Busy),      32'd0);
        chk("idle_lag",   32'(bus.BestLag),   32'(e.lag));
        chk("idle_score", 32'(bus.BestScore), 32'(e.score));
    endtask

    task automatic reset_mid_scan(input logic [W-1:0] r, input logic [OW-1:0] o);
        bus.Start   = 1'b1;
        bus.DataIn1 = r;
        bus.DataIn2 = o;
        tick();
        bus.Start = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        chk("rst_busy",   32'(bus.Busy),      32'd0);
        chk("rst_valid",  32'(bus.OutValid),  32'd0);
        chk("rst_score",  32'(bus.BestScore), 32'd0);
        chk("rst_lag",    32'(bus.BestLag),   32'd0);
        chk("rst_detect", 32'(bus.Detect),    32'd0);
        rst_n = 1'b1;
        repeat (12) begin
            tick();
            chk("rst_no_valid", 32'(bus.OutValid), 32'd0);
        end
    endtask

    initial begin
        logic [W-1:0]  r;
        logic [OW-1:0] o;
        rst_n        = 1'b0;
        bus.Start    = 1'b0;
        bus.DataIn1  = '0;
        bus.DataIn2  = '0;
        bus.OutReady = 1'b0;
        repeat (3) tick();
        chk("reset_busy",     32'(bus.Busy),      32'd0);
        chk("reset_valid",    32'(bus.OutValid),  32'd0);
        chk("reset_lag",      32'(bus.BestLag),   32'd0);
        chk("reset_score",    32'(bus.BestScore), 32'd0);
        chk("reset_detect",   32'(bus.Detect),    32'd0);
        chk("reset_inverted", 32'(bus.Inverted),  32'd0);
        rst_n = 1'b1;
        tick();

        r = 16'hA5C3;
        o = OW'(r) << 3;
        run(r, o, 2);                         // exact match at lag 3
        run(16'hFFFF, '1, 0);                 // all-lag tie
        run(16'hFFFF, '0, 5);                 // no match, with backpressure
        reset_mid_scan(r, o);
        run(r, o, 1);                         // same result after the abort
        run(16'hFFFF, OW'(23'h003FFF), 0);    // best score 14
        run(16'hFFFF, OW'(23'h001FFF), 0);    // best score 13

        for (int n = 0; n < 20; n++) begin
            r = W'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                o = OW'($urandom) ^ (OW'(r) << $urandom_range(0, MAX_LAG));
                o = o & ~(OW'($urandom) & OW'($urandom) & OW'($urandom));
            end else begin
                o = OW'($urandom);
            end
            run(r, o, int'($urandom_range(0, 3)));
        end

        repeat (2) tick();
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/sliding_correlator.md
Name: sliding_correlator

Overview:
- Clocked, parametrised successor to the latch/precharge correlator.
- Captures a reference word (DataIn1) and a longer observation word (DataIn2) of oversampled symbols.
- Sweeps every lag 0..MAX_LAG, one lag per cycle, and scores each lag as the count of matching bits.
- Reports best lag, score and threshold detection over a valid/ready handshake to the downstream sync/decision logic.

Parameters:
SAMPLES, 2, symbols per correlation window
OSF, 8, oversampling factor; window width W = SAMPLES*OSF
MAX_LAG, 7, highest lag evaluated (>=1); DataIn2 width = W+MAX_LAG
THRESH, 14, minimum BestScore for Detect (0..W)

Ports:
Clk  in  1  rising-edge clock
Rst_n  in  1  synchronous active-low reset
Start  in  1  request; accepted only in IDLE
DataIn1  in  W  reference pattern, sampled on the accepting edge
DataIn2  in  W+MAX_LAG  observation window, sampled on the accepting edge
Busy  out  1  high in SCAN and DONE
OutValid  out  1  result valid
OutReady  in  1  downstream accepts result
BestLag  out  clog2(MAX_LAG+1)  winning lag
BestScore  out  clog2(W+1)  match count at BestLag
Detect  out  1  BestScore >= THRESH
Inverted  out  1  winner is anti-correlated (optional feature only)

Behaviour:
- Clock and reset: one clock Clk; Rst_n is synchronous and active-low.
- Reset values: FSM=IDLE; Busy, OutValid, Detect, Inverted = 0; BestLag = 0; BestScore = 0; internal registers cleared.
- FSM states: IDLE, SCAN, DONE.
- IDLE -> SCAN on Start=1.
  - DataIn1 and DataIn2 are registered on that edge.
  - Lag counter and best registers are cleared.
- SCAN, lag L:
  - score = popcount(~(Ref ^ Obs[L +: W])).
  - If L==0 or score > best: best updates to (L, score).
  - Ties keep the smaller lag.
  - After L==MAX_LAG the FSM moves to DONE.
- DONE:
  - OutValid=1; BestLag, BestScore, Detect, Inverted held stable.
  - DONE -> IDLE on OutValid&&OutReady; OutValid drops the next cycle.
- Latency: Start accepted at edge 0; lags evaluated in cycles 1..MAX_LAG+1; OutValid high from cycle MAX_LAG+2 (cycle 9 with defaults).
- Start outside IDLE is ignored, including a Start in the same cycle as the output handshake. Earliest re-accept is the cycle after the FSM returns to IDLE.
- Input changes after acceptance have no effect on the result in progress.
- Outputs keep the last result in IDLE until the next accepted Start clears them at SCAN entry. OutValid is 0 outside DONE.
- Arithmetic: the score counter is clog2(W+1) bits wide and cannot overflow. The comparison is unsigned.
- Reset mid-SCAN or mid-DONE: return to the reset state at that edge; the partial result is discarded with no OutValid pulse.

Optional Feature:
- Macro: CORR_ABS_EN.
- Defined: effective score = max(m, W-m), where m is the match count.
  - Inverted=1 when W-m > m is chosen; when m == W-m, Inverted=0.
  - Tie-break on the effective score as above.
- Undefined: score = m; Inverted tied 0; no extra logic.

Decomposition:
- Package corr_pkg:
  - FSM state enum (IDLE/SCAN/DONE).
  - Width helper functions for score and lag widths.
- Sub-module xnor_popcount (parameter W): combinational match count of two W-bit words. Instantiated once and reused every SCAN cycle.

Test Plan:
- Exact match: W=16, MAX_LAG=7. DataIn1=16'hA5C3; DataIn2 zero except bits [18:3]=16'hA5C3; Start -> OutValid at cycle 9, BestLag=3, BestScore=16, Detect=1.
- Ties: DataIn1=16'hFFFF, DataIn2=all ones -> every lag scores 16; BestLag=0, BestScore=16, Detect=1.
- Backpressure: hold OutReady=0 for 5 cycles in DONE while pulsing Start -> outputs stable, Start ignored. Raise OutReady -> next cycle OutValid=0, Busy=0. A following Start is accepted.
- Reset mid-scan: drive Rst_n=0 during lag 4 -> next cycle Busy=0, OutValid=0, BestScore=0, BestLag=0. A subsequent scenario-1 run gives the scenario-1 result.
- No match: DataIn1=16'hFFFF, DataIn2=0.
  - Without CORR_ABS_EN: BestScore=0, BestLag=0, Detect=0, Inverted=0.
  - With CORR_ABS_EN: BestScore=16, BestLag=0, Inverted=1, Detect=1.
- Threshold edge: THRESH=14, a best-lag score of exactly 14 -> Detect=1; a best score of 13 -> Detect=0.
